router_drain_scheduler: RTL and testbench
=========================================

Name: router_drain_scheduler

Overview:
- Drains the three router output FIFOs into one shared 8-bit egress stream, one whole packet at a time.
- Arbitrates round-robin among the non-empty FIFOs and drives read_enb_0/1/2.
- Parses each packet's header to know how many bytes to read, and presents the bytes on a valid/ready port with packet framing.
- Sits between router_top's output side and the downstream link/serializer.

Parameters:
- STALL_TIMEOUT, 64: consecutive cycles with the granted FIFO empty mid-packet before the packet is aborted; legal range 2..255.
- TO_W, 8: width of the stall counter; must satisfy 2^TO_W > STALL_TIMEOUT.

Ports:
- clock  input  1  single clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- vld_out_0, vld_out_1, vld_out_2  input  1 each  FIFO n non-empty.
- data_out_0, data_out_1, data_out_2  input  8 each  FIFO n read data, valid the cycle after read_enb_n.
- read_enb_0, read_enb_1, read_enb_2  output  1 each  FIFO n read strobe; at most one high per cycle.
- m_data  output  8  egress byte.
- m_valid  output  1  egress byte valid.
- m_ready  input  1  downstream accepts; transfer = m_valid & m_ready.
- m_sop  output  1  the m_data byte is a header byte.
- m_eop  output  1  the m_data byte is a parity byte, i.e. the last byte of the packet.
- m_port  output  2  source FIFO index (0..2) of the m_data byte.
- pkt_abort  output  1  one-cycle pulse when the current packet is abandoned.
- sched_busy  output  1  high from grant until the packet's last read data lands in the buffer.

Behaviour:
- Packet format: header[7:2] = payload length L (0..63), header[1:0] = address; then L payload bytes; then 1 parity byte. Total reads = L+2.
- Reset values: read_enb_* = 0, m_valid = 0, m_data = 0, m_sop = 0, m_eop = 0, m_port = 0, pkt_abort = 0, sched_busy = 0. Round-robin pointer = 0, state = IDLE, buffer empty.
- Egress buffer: 2-entry FIFO holding {data, sop, eop, port}. m_* always reflect the head entry.
- Read issue rule (all states): a read may be issued only if buffer occupancy + reads in flight (0 or 1) < 2, after accounting for a transfer in the same cycle. This gives full throughput at m_ready = 1 and no loss under backpressure.
- Read data: captured into the buffer the cycle after read_enb. sop = 1 on the header byte; eop = 1 on the parity byte.
- IDLE:
  - If any vld_out_n is high, grant the first requester searching from the rr pointer (pointer, pointer+1, pointer+2 mod 3).
  - Register grant g, go to HDR.
  - The grant decision takes 1 cycle; no read is issued in IDLE.
- HDR:
  - When vld_out_g = 1 and the issue rule allows, assert read_enb_g for one cycle, go to HWAIT.
- HWAIT:
  - Header data arrives; set remaining = header[7:2] + 1; go to BODY.
  - If the issue rule allows and vld_out_g = 1, a body read may be issued in this same cycle (back-to-back).
- BODY:
  - Issue a read whenever vld_out_g = 1, the issue rule allows, and remaining > 0; decrement remaining on each issue.
  - When the last read has been issued (remaining reaches 0), go to LAST.
- LAST:
  - Wait for the final read data to enter the buffer.
  - Set rr pointer = g+1 mod 3, deassert sched_busy, go to IDLE.
  - Result: minimum 2-cycle bubble between packets.
- Stall timeout:
  - In HDR or BODY, count consecutive cycles in which the grant is pending and vld_out_g = 0; clear the count on any issued read.
  - When the count reaches STALL_TIMEOUT: pulse pkt_abort, advance the rr pointer past g, go to IDLE.
  - Bytes already in the buffer are still delivered; no eop is synthesized.
- Stall under backpressure: stall cycles caused by a full buffer (m_ready = 0) do not count toward the timeout.
- L = 0: HWAIT sets remaining = 1, so exactly one parity read follows the header.
- Simultaneous events: a same-cycle transfer and read-data capture keep occupancy constant. Requests arriving on non-granted ports never preempt a packet in progress.
- Reset mid-packet: all state returns to reset values immediately and asynchronously; buffered bytes are discarded.

Test Plan:
- Single packet, FIFO0 holds header 0x0C (L=3, addr 0) + 3 payload bytes + parity, m_ready = 1 -> read_enb_0 high 5 cycles, back-to-back after the header. m_data sequence 0x0C, payload, parity. m_sop on byte 1, m_eop on byte 5, m_port = 0, sched_busy falls after the 5th capture.
- All three FIFOs loaded at once, each with L=1, rr pointer = 0 -> packets egress in port order 0, 1, 2. A fourth packet on port 0 queued during packet 1 waits until port 2's packet completes.
- Backpressure: L=4 packet, m_ready toggled 1,0,0,1,... -> no byte lost or duplicated, and buffer occupancy never exceeds 2. read_enb stays low while occupancy + in-flight = 2.
- L=0 header 0x01 on FIFO1 -> exactly 2 reads. m_sop and m_eop land on consecutive bytes, m_port = 1.
- Stall: grant FIFO2, header says L=5, only 2 payload bytes present, vld_out_2 then held low with STALL_TIMEOUT = 64 -> pkt_abort pulses exactly 64 cycles after the last read, state returns to IDLE, next grant goes to port 0.
- Assert resetn low during BODY -> all outputs reach reset values without a clock edge. After release, the first packet on FIFO1 is granted normally.

Source files
------------

// File: rtl/router_drain_scheduler.sv
`timescale 1ns/1ps
// router_drain_scheduler
// Drains the three router output FIFOs into one shared 8-bit valid/ready
// egress stream, one whole packet at a time, with round-robin arbitration.
//
// Ports:
//   clock, resetn            : clock (rising edge), asynchronous active-low reset
//   vld_out_n, data_out_n    : FIFO n non-empty / read data (valid cycle after read_enb_n)
//   read_enb_n               : FIFO n read strobe, at most one high per cycle
//   m_data, m_valid, m_ready : egress byte stream, transfer = m_valid & m_ready
//   m_sop, m_eop, m_port     : header byte / parity byte / source FIFO of m_data
//   pkt_abort                : one-cycle pulse when a stalled packet is abandoned
//   sched_busy               : high from grant until last read data is buffered
module router_drain_scheduler #(
    parameter int STALL_TIMEOUT = 64,
    parameter int TO_W          = 8
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       vld_out_0,
    input  logic       vld_out_1,
    input  logic       vld_out_2,
    input  logic [7:0] data_out_0,
    input  logic [7:0] data_out_1,
    input  logic [7:0] data_out_2,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sop,
    output logic       m_eop,
    output logic [1:0] m_port,
    output logic       pkt_abort,
    output logic       sched_busy
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_HWAIT, S_BODY, S_LAST} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  rr_q, rr_d;
    logic [6:0]  rem_q, rem_d;
    logic [TO_W-1:0] stall_q, stall_d;

    // Read issued last cycle: its data is captured into the buffer this cycle.
    logic        infl_q, infl_sop_q, infl_eop_q;
    logic [1:0]  infl_port_q;

    // Two-entry egress buffer, entry = {port[1:0], sop, eop, data[7:0]}.
    logic [11:0] buf_q [2];
    logic        wr_q, rd_q;
    logic [1:0]  cnt_q;

    logic        issue, issue_sop, issue_eop, abort;
    logic [2:0]  vld_vec;
    logic        vld_g;
    logic [7:0]  cap_data;
    logic        xfer;
    logic        room;
    logic [6:0]  hdr_len;
    logic [1:0]  c0, c1, c2;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign vld_vec  = {vld_out_2, vld_out_1, vld_out_0};
    assign vld_g    = vld_vec[grant_q];
    assign xfer     = m_valid & m_ready;
    // Occupancy after this cycle's capture and transfer must leave space for
    // a new read, whose data lands next cycle.
    assign room     = (cnt_q + 2'(infl_q) - 2'(xfer)) < 2'd2;
    assign hdr_len  = {1'b0, cap_data[7:2]} + 7'd1;
    assign c0       = rr_q;
    assign c1       = next_port(c0);
    assign c2       = next_port(c1);

    always_comb begin
        case (infl_port_q)
            2'd0:    cap_data = data_out_0;
            2'd1:    cap_data = data_out_1;
            default: cap_data = data_out_2;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'd0;
            rr_q        <= 2'd0;
            rem_q       <= 7'd0;
            stall_q     <= '0;
            infl_q      <= 1'b0;
            infl_sop_q  <= 1'b0;
            infl_eop_q  <= 1'b0;
            infl_port_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            rem_q       <= rem_d;
            stall_q     <= stall_d;
            infl_q      <= issue;
            infl_sop_q  <= issue_sop;
            infl_eop_q  <= issue_eop;
            infl_port_q <= grant_q;
        end
    end

    // Next-state logic, including read issue and stall timeout
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        rem_d     = rem_q;
        stall_d   = stall_q;
        issue     = 1'b0;
        issue_sop = 1'b0;
        issue_eop = 1'b0;
        abort     = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_d = '0;
                if (vld_vec != 3'b000) begin
                    grant_d = vld_vec[c0] ? c0 : (vld_vec[c1] ? c1 : c2);
                    state_d = S_HDR;
                end
            end
            S_HDR, S_BODY: begin
                if (!vld_g) begin
                    // Only an empty granted FIFO counts as a stall; a full
                    // buffer with data waiting just holds the count.
                    if (stall_q == TO_W'(STALL_TIMEOUT - 1)) begin
                        abort   = 1'b1;
                        rr_d    = next_port(grant_q);
                        stall_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        stall_d = stall_q + TO_W'(1);
                    end
                end else if (room) begin
                    issue   = 1'b1;
                    stall_d = '0;
                    if (state_q == S_HDR) begin
                        issue_sop = 1'b1;
                        state_d   = S_HWAIT;
                    end else begin
                        rem_d     = rem_q - 7'd1;
                        issue_eop = (rem_q == 7'd1);
                        if (rem_q == 7'd1) state_d = S_LAST;
                    end
                end
            end
            S_HWAIT: begin
                // Header byte is on cap_data now; remaining = payload + parity.
                rem_d   = hdr_len;
                state_d = S_BODY;
                if (vld_g && room) begin
                    issue     = 1'b1;
                    stall_d   = '0;
                    rem_d     = hdr_len - 7'd1;
                    issue_eop = (hdr_len == 7'd1);
                    if (hdr_len == 7'd1) state_d = S_LAST;
                end
            end
            S_LAST: begin
                // The final read is in flight and is captured this cycle.
                rr_d    = next_port(grant_q);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Egress buffer
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) buf_q[i] <= 12'd0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (infl_q) begin
                buf_q[wr_q] <= {infl_port_q, infl_sop_q, infl_eop_q, cap_data};
                wr_q        <= ~wr_q;
            end
            if (xfer) rd_q <= ~rd_q;
            cnt_q <= cnt_q + 2'(infl_q) - 2'(xfer);
        end
    end

    // Outputs
    always_comb begin
        read_enb_0 = issue && (grant_q == 2'd0);
        read_enb_1 = issue && (grant_q == 2'd1);
        read_enb_2 = issue && (grant_q == 2'd2);
        m_valid    = (cnt_q != 2'd0);
        {m_port, m_sop, m_eop, m_data} = buf_q[rd_q];
        pkt_abort  = abort;
        sched_busy = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_router_drain_scheduler.sv
`timescale 1ns/1ps
// Directed bench for router_drain_scheduler: FIFO models on the ingress side,
// byte collector and occupancy tracker on the egress side.
module tb_router_drain_scheduler;

    logic       clock = 1'b0;
    logic       resetn;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic [7:0] data_out_0, data_out_1, data_out_2;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [7:0] m_data;
    logic       m_valid, m_ready, m_sop, m_eop;
    logic [1:0] m_port;
    logic       pkt_abort, sched_busy;

    always #5 clock = ~clock;

    router_drain_scheduler #(.STALL_TIMEOUT(64), .TO_W(8)) dut (
        .clock(clock), .resetn(resetn),
        .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
        .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sop(m_sop), .m_eop(m_eop), .m_port(m_port),
        .pkt_abort(pkt_abort), .sched_busy(sched_busy)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0]  fq0[$], fq1[$], fq2[$];
    logic [11:0] rx_q[$], exp_q[$];
    int re_cnt[3], first_re[3], last_re[3];
    int busy_cnt, abort_cnt, abort_cyc;
    int occ, occ_eff;
    logic re_prev, xf;
    logic [2:0] re_s;
    logic [3:0] pat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input logic [7:0] b);
        case (p)
            0: begin fq0.push_back(b); vld_out_0 = 1'b1; end
            1: begin fq1.push_back(b); vld_out_1 = 1'b1; end
            default: begin fq2.push_back(b); vld_out_2 = 1'b1; end
        endcase
    endtask

    task automatic expect_byte(input int p, input logic s, input logic e, input logic [7:0] d);
        exp_q.push_back({2'(p), s, e, d});
    endtask

    task automatic send(input int p, input logic [7:0] hdr, input logic [7:0] pay0,
                        input int npay, input logic [7:0] par, input bit has_par);
        push(p, hdr);
        expect_byte(p, 1'b1, 1'b0, hdr);
        for (int i = 0; i < npay; i++) begin
            push(p, pay0 + 8'(i));
            expect_byte(p, 1'b0, 1'b0, pay0 + 8'(i));
        end
        if (has_par) begin
            push(p, par);
            expect_byte(p, 1'b0, 1'b1, par);
        end
    endtask

    task automatic clr();
        for (int n = 0; n < 3; n++) begin re_cnt[n] = 0; first_re[n] = 0; last_re[n] = 0; end
        busy_cnt = 0; abort_cnt = 0; abort_cyc = 0;
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic flush_fifos();
        fq0.delete(); fq1.delete(); fq2.delete();
        vld_out_0 = 1'b0; vld_out_1 = 1'b0; vld_out_2 = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        flush_fifos();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic wait_rx(input int n, input string tag);
        int k;
        k = 0;
        while (rx_q.size() < n && k < 1000) begin @(negedge clock); k++; end
        chk({tag, "_arrived"}, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx_q.size()) chk($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_read_enb"}, 32'({read_enb_2, read_enb_1, read_enb_0}), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_m_sop"}, 32'(m_sop), 32'd0);
        chk({tag, "_m_eop"}, 32'(m_eop), 32'd0);
        chk({tag, "_m_port"}, 32'(m_port), 32'd0);
        chk({tag, "_pkt_abort"}, 32'(pkt_abort), 32'd0);
        chk({tag, "_sched_busy"}, 32'(sched_busy), 32'd0);
    endtask

    // FIFO models and egress monitor. Sampling at the edge sees pre-edge DUT
    // values; FIFO outputs change 1 ns after the edge.
    always @(posedge clock) begin
        if (!resetn) begin
            occ = 0; re_prev = 1'b0; re_s = 3'b000;
        end else begin
            cyc++;
            re_s = {read_enb_2, read_enb_1, read_enb_0};
            xf = m_valid & m_ready;
            chk("mon_m_valid", 32'(m_valid), 32'(occ != 0));
            chk("mon_read_onehot", 32'($countones(re_s) <= 1), 32'd1);
            occ_eff = occ + int'(re_prev) - int'(xf);
            if (re_s != 3'b000) chk("mon_read_room", 32'(occ_eff < 2), 32'd1);
            occ = occ_eff;
            re_prev = |re_s;
            if (xf) rx_q.push_back({m_port, m_sop, m_eop, m_data});
            for (int n = 0; n < 3; n++)
                if (re_s[n]) begin
                    if (re_cnt[n] == 0) first_re[n] = cyc;
                    last_re[n] = cyc;
                    re_cnt[n]++;
                end
            if (sched_busy) busy_cnt++;
            if (pkt_abort) begin abort_cnt++; abort_cyc = cyc; end
        end
        #1;
        if (re_s[0] && fq0.size() > 0) data_out_0 = fq0.pop_front();
        if (re_s[1] && fq1.size() > 0) data_out_1 = fq1.pop_front();
        if (re_s[2] && fq2.size() > 0) data_out_2 = fq2.pop_front();
        vld_out_0 = (fq0.size() != 0);
        vld_out_1 = (fq1.size() != 0);
        vld_out_2 = (fq2.size() != 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; m_ready = 1'b1;
        vld_out_0 = 1'b0; vld_out_1 = 1'b0; vld_out_2 = 1'b0;
        data_out_0 = 8'h00; data_out_1 = 8'h00; data_out_2 = 8'h00;
        pat = 4'b1001;
        clr();
        repeat (3) @(negedge clock);
        check_rst("rst");
        resetn = 1'b1;
        @(negedge clock);

        // Single L=3 packet on FIFO0
        clr();
        send(0, 8'h0C, 8'hA1, 3, 8'h5E, 1'b1);
        wait_rx(5, "t1");
        repeat (4) @(negedge clock);
        check_rx("t1");
        chk("t1_reads", 32'(re_cnt[0]), 32'd5);
        chk("t1_back_to_back", 32'(last_re[0] - first_re[0]), 32'd4);
        chk("t1_busy_cycles", 32'(busy_cnt), 32'd6);
        chk("t1_busy_low", 32'(sched_busy), 32'd0);

        // Round robin across three loaded FIFOs, late port 0 packet waits
        do_reset();
        clr();
        send(0, 8'h04, 8'h11, 1, 8'h90, 1'b1);
        send(1, 8'h05, 8'h21, 1, 8'h91, 1'b1);
        send(2, 8'h06, 8'h31, 1, 8'h92, 1'b1);
        wait_rx(4, "t2_mid");
        send(0, 8'h04, 8'h12, 1, 8'h93, 1'b1);
        wait_rx(12, "t2");
        repeat (4) @(negedge clock);
        check_rx("t2");

        // Backpressure with m_ready pattern 1,0,0,1
        clr();
        send(0, 8'h10, 8'hB1, 4, 8'h77, 1'b1);
        for (int k = 0; k < 400 && rx_q.size() < 6; k++) begin
            m_ready = pat[k % 4];
            @(negedge clock);
        end
        m_ready = 1'b1;
        chk("t3_arrived", 32'(rx_q.size() >= 6), 32'd1);
        repeat (6) @(negedge clock);
        check_rx("t3");
        chk("t3_reads", 32'(re_cnt[0]), 32'd6);

        // L=0 packet on FIFO1
        clr();
        send(1, 8'h01, 8'h00, 0, 8'h3C, 1'b1);
        wait_rx(2, "t4");
        repeat (4) @(negedge clock);
        check_rx("t4");
        chk("t4_reads", 32'(re_cnt[1]), 32'd2);
        chk("t4_busy_cycles", 32'(busy_cnt), 32'd3);

        // Stall timeout on FIFO2: L=5 header but only 2 payload bytes
        clr();
        send(2, 8'h16, 8'hC1, 2, 8'h00, 1'b0);
        for (int k = 0; k < 300 && abort_cnt < 1; k++) @(negedge clock);
        chk("t5_abort_seen", 32'(abort_cnt >= 1), 32'd1);
        @(negedge clock);
        chk("t5_busy_low", 32'(sched_busy), 32'd0);
        chk("t5_abort_delay", 32'(abort_cyc - last_re[2]), 32'd64);
        chk("t5_reads", 32'(re_cnt[2]), 32'd3);
        wait_rx(3, "t5");
        repeat (2) @(negedge clock);
        check_rx("t5");
        chk("t5_abort_pulses", 32'(abort_cnt), 32'd1);
        clr();
        send(0, 8'h00, 8'h00, 0, 8'hE0, 1'b1);
        send(1, 8'h01, 8'h00, 0, 8'hE1, 1'b1);
        send(2, 8'h02, 8'h00, 0, 8'hE2, 1'b1);
        wait_rx(6, "t5_next");
        repeat (4) @(negedge clock);
        check_rx("t5_next");

        // Asynchronous reset during BODY
        clr();
        send(0, 8'h0C, 8'hD1, 3, 8'h6A, 1'b1);
        for (int k = 0; k < 100 && re_cnt[0] < 3; k++) @(negedge clock);
        chk("t6_busy_before", 32'(sched_busy), 32'd1);
        #2 resetn = 1'b0;
        #1 check_rst("t6");
        flush_fifos();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        clr();
        send(1, 8'h05, 8'h44, 1, 8'h55, 1'b1);
        wait_rx(3, "t6_after");
        repeat (4) @(negedge clock);
        check_rx("t6_after");
        chk("t6_reads", 32'(re_cnt[1]), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
